// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: raster timing presets, counter widths and a line/frame total helper.
package vga_timing_pkg;
   localparam int X_W = 11;
   localparam int Y_W = 10;
   // 800x600@72 from a 50 MHz board clock
   localparam int   SVGA_H_ACT   = 800;
   localparam int   SVGA_H_FP    = 56;
   localparam int   SVGA_H_SYNC  = 120;
   localparam int   SVGA_H_BP    = 64;
   localparam int   SVGA_V_ACT   = 600;
   localparam int   SVGA_V_FP    = 37;
   localparam int   SVGA_V_SYNC  = 6;
   localparam int   SVGA_V_BP    = 23;
   localparam logic SVGA_H_POL   = 1'b1;
   localparam logic SVGA_V_POL   = 1'b1;
   localparam int   SVGA_PIX_DIV = 1;
   // 640x480@60, pixel clock is half the board clock
   localparam int   VGA_H_ACT    = 640;
   localparam int   VGA_H_FP     = 16;
   localparam int   VGA_H_SYNC   = 96;
   localparam int   VGA_H_BP     = 48;
   localparam int   VGA_V_ACT    = 480;
   localparam int   VGA_V_FP     = 10;
   localparam int   VGA_V_SYNC   = 2;
   localparam int   VGA_V_BP     = 33;
   localparam logic VGA_H_POL    = 1'b0;
   localparam logic VGA_V_POL    = 1'b0;
   localparam int   VGA_PIX_DIV  = 2;
   function automatic int total(int act, int fp, int sync, int bp);
      return act + fp + sync + bp;
   endfunction
endpackage

// File: rtl/pix_strobe_div.sv
// pix_strobe_div: strobes on the clk_in cycle in which a 0..PIX_DIV-1 divider wraps.
module pix_strobe_div #(
   parameter int PIX_DIV = 1
) (
   input  logic clk_in,
   input  logic i_rst_n,
   output logic o_stb
);
   localparam int W = PIX_DIV > 1 ? $clog2(PIX_DIV) : 1;
   localparam logic [W-1:0] LAST = W'(PIX_DIV - 1);
   logic [W-1:0] cnt;
   assign o_stb = cnt == LAST;
   always_ff @(posedge clk_in or negedge i_rst_n)
      if (!i_rst_n) cnt <= '0;
      else cnt <= o_stb ? '0 : cnt + 1'b1;
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster counters with registered sync/active/position outputs and frame/vblank pulses.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int   H_ACT   = SVGA_H_ACT,
   parameter int   H_FP    = SVGA_H_FP,
   parameter int   H_SYNC  = SVGA_H_SYNC,
   parameter int   H_BP    = SVGA_H_BP,
   parameter int   V_ACT   = SVGA_V_ACT,
   parameter int   V_FP    = SVGA_V_FP,
   parameter int   V_SYNC  = SVGA_V_SYNC,
   parameter int   V_BP    = SVGA_V_BP,
   parameter logic H_POL   = SVGA_H_POL,
   parameter logic V_POL   = SVGA_V_POL,
   parameter int   PIX_DIV = SVGA_PIX_DIV
) (
   input  logic           clk_in,
   input  logic           i_rst_n,
   output logic           o_hsync,
   output logic           o_vsync,
   output logic           o_active,
   output logic [X_W-1:0] o_x,
   output logic [Y_W-1:0] o_y,
   output logic           o_pix_stb,
   output logic           o_frame,
   output logic           o_vblank
);
   localparam int H_TOTAL = total(H_ACT, H_FP, H_SYNC, H_BP);
   localparam int V_TOTAL = total(V_ACT, V_FP, V_SYNC, V_BP);
   if (H_TOTAL > 2048 || V_TOTAL > 1024 || PIX_DIV < 1) begin : g_bad_cfg
      $error("vga_timing_gen: unsupported timing parameters");
   end
   localparam logic [X_W-1:0] HA  = X_W'(H_ACT);
   localparam logic [X_W-1:0] HS0 = X_W'(H_ACT + H_FP);
   localparam logic [X_W-1:0] HS1 = X_W'(H_ACT + H_FP + H_SYNC - 1);
   localparam logic [X_W-1:0] HL  = X_W'(H_TOTAL - 1);
   localparam logic [Y_W-1:0] VA  = Y_W'(V_ACT);
   localparam logic [Y_W-1:0] VS0 = Y_W'(V_ACT + V_FP);
   localparam logic [Y_W-1:0] VS1 = Y_W'(V_ACT + V_FP + V_SYNC - 1);
   localparam logic [Y_W-1:0] VL  = Y_W'(V_TOTAL - 1);
   logic           stb;
   logic [X_W-1:0] hc;
   logic [Y_W-1:0] vc;
   pix_strobe_div #(.PIX_DIV(PIX_DIV)) u_div (
      .clk_in  (clk_in),
      .i_rst_n (i_rst_n),
      .o_stb   (stb)
   );
   // Outputs show the pre-increment counters, so they trail hc/vc by one strobe.
   always_ff @(posedge clk_in or negedge i_rst_n)
      if (!i_rst_n) begin
         hc        <= '0;
         vc        <= '0;
         o_x       <= '0;
         o_y       <= '0;
         o_active  <= 1'b0;
         o_hsync   <= !H_POL;
         o_vsync   <= !V_POL;
         o_pix_stb <= 1'b0;
         o_frame   <= 1'b0;
         o_vblank  <= 1'b0;
      end else begin
         o_pix_stb <= stb;
         o_frame   <= stb && hc == '0 && vc == '0;
         o_vblank  <= stb && hc == '0 && vc == VA;
         if (stb) begin
            o_x      <= hc;
            o_y      <= vc;
            o_active <= hc < HA && vc < VA;
            o_hsync  <= (hc >= HS0 && hc <= HS1) ? H_POL : !H_POL;
            o_vsync  <= (vc >= VS0 && vc <= VS1) ? V_POL : !V_POL;
            hc       <= hc == HL ? '0 : hc + 1'b1;
            if (hc == HL) vc <= vc == VL ? '0 : vc + 1'b1;
         end
      end
endmodule
